// File: rtl/ahb_response_mux_if.sv
// AHB-Lite return-path bundle between decoder/slaves, the response mux and the master.
// Latency: none (wires only).
// Backpressure: m_hready_o carries slave/default-slave wait states back to the master.
// Ports (suffixes are from the mux's point of view):
//   m_htrans_i, m_hready_o, m_hresp_o, m_hrdata_o  - master side
//   s_hsel_i, s_hreadyout_i, s_hresp_i, s_hrdata_i - decoder and slave side
// Modport slave is the mux view; modport master is the view of whatever drives the mux.
interface ahb_response_mux_if #(
  parameter int SLV_NUMBER = 16,
  parameter int DATA_WIDTH = 32
);
  logic [1:0]                       m_htrans_i;
  logic                             m_hready_o;
  logic                             m_hresp_o;
  logic [DATA_WIDTH-1:0]            m_hrdata_o;
  logic [SLV_NUMBER-1:0]            s_hsel_i;
  logic [SLV_NUMBER-1:0]            s_hreadyout_i;
  logic [SLV_NUMBER-1:0]            s_hresp_i;
  logic [SLV_NUMBER*DATA_WIDTH-1:0] s_hrdata_i;

  modport slave (
    input  m_htrans_i, s_hsel_i, s_hreadyout_i, s_hresp_i, s_hrdata_i,
    output m_hready_o, m_hresp_o, m_hrdata_o
  );

  modport master (
    output m_htrans_i, s_hsel_i, s_hreadyout_i, s_hresp_i, s_hrdata_i,
    input  m_hready_o, m_hresp_o, m_hrdata_o
  );
endinterface

// File: rtl/ahb_response_mux.sv
// AHB-Lite response mux with built-in default slave (two-cycle ERROR for unmapped NONSEQ/SEQ).
// Latency: 0 cycles added; data-phase outputs are combinational from captured owner + slave inputs.
// Backpressure: owner capture only on m_hready_o=1, so slave waits freeze routing.
// Ports:
//   clk_i, rst_i - HCLK and asynchronous active-high reset
//   bus          - ahb_response_mux_if.slave (master HTRANS/HREADY/HRESP/HRDATA, per-slave HSEL/HREADYOUT/HRESP/HRDATA)
module ahb_response_mux #(
  parameter int SLV_NUMBER = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  ahb_response_mux_if.slave  bus
);

  localparam int SEL_W = (SLV_NUMBER > 1) ? $clog2(SLV_NUMBER) : 1;

  typedef enum logic [1:0] {DS_OKAY, DS_ERR1, DS_ERR2} ds_state_e;

  ds_state_e             ds_state_q, ds_state_d;
  logic                  slv_q, slv_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic                  ds_err_q, ds_err_d;

  logic                  any_sel;
  logic [SEL_W-1:0]      owner;
  logic                  hready;
  logic                  hresp;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  ds_hready;
  logic                  ds_hresp;
  logic                  unmapped_xfer;

  assign any_sel = |bus.s_hsel_i;

  // Scan from the top so the lowest set HSEL bit is the last write and wins.
  always_comb begin
    owner = '0;
    for (int i = SLV_NUMBER - 1; i >= 0; i--) begin
      if (bus.s_hsel_i[i]) owner = SEL_W'(i);
    end
  end

  // An accepted address phase that nobody claims and that really transfers.
  assign unmapped_xfer = hready & ~any_sel & bus.m_htrans_i[1];

  // Data-phase owner capture.
  always_comb begin
    slv_d    = slv_q;
    sel_d    = sel_q;
    ds_err_d = ds_err_q;
    if (hready) begin
      slv_d    = any_sel;
      sel_d    = owner;
      ds_err_d = ~any_sel & bus.m_htrans_i[1];
    end
  end

  // Default slave FSM. ERR1 cannot accept an address (hready=0), ERR2 can,
  // so a pipelined unmapped transfer re-enters ERR1 directly.
  always_comb begin
    ds_state_d = ds_state_q;
    ds_hready  = 1'b1;
    ds_hresp   = 1'b0;
    case (ds_state_q)
      DS_OKAY: begin
        if (unmapped_xfer) ds_state_d = DS_ERR1;
      end
      DS_ERR1: begin
        ds_hready  = 1'b0;
        ds_hresp   = ds_err_q;
        ds_state_d = DS_ERR2;
      end
      DS_ERR2: begin
        ds_hresp   = ds_err_q;
        ds_state_d = unmapped_xfer ? DS_ERR1 : DS_OKAY;
      end
      default: ds_state_d = DS_OKAY;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ds_state_q <= DS_OKAY;
      slv_q      <= 1'b0;
      sel_q      <= '0;
      ds_err_q   <= 1'b0;
    end else begin
      ds_state_q <= ds_state_d;
      slv_q      <= slv_d;
      sel_q      <= sel_d;
      ds_err_q   <= ds_err_d;
    end
  end

  // Return-path mux.
  always_comb begin
    hready = ds_hready;
    hresp  = ds_hresp;
    hrdata = '0;
    if (slv_q) begin
      hready = bus.s_hreadyout_i[sel_q];
      hresp  = bus.s_hresp_i[sel_q];
      hrdata = bus.s_hrdata_i[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.m_hready_o = hready;
  assign bus.m_hresp_o  = hresp;
  assign bus.m_hrdata_o = hrdata;

endmodule

// File: doc/ahb_response_mux.md
# ahb_response_mux

AHB-Lite slave-to-master return path and default slave. Takes the one-hot select vector produced by the address decoder, captures it at each accepted address phase, and uses the captured data-phase owner to route that slave's HRDATA/HREADYOUT/HRESP back to the single master. Unmapped NONSEQ/SEQ transfers go to a built-in default slave, which returns the standard two-cycle ERROR response. The block sits between the decoder/slaves and the master port of each AHB-Lite segment.

## Interface
- SLV_NUMBER, default 16: number of slave ports, 1..64.
- DATA_WIDTH, default 32: HRDATA width, 32 or 64.
- clk_i  in  1  HCLK.
- rst_i  in  1  asynchronous, active-high reset.
- m_htrans_i  in  2  master HTRANS (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- m_hready_o  out  1  HREADY to the master; also the HREADY input of every slave.
- m_hresp_o  out  1  HRESP to the master (0=OKAY, 1=ERROR).
- m_hrdata_o  out  DATA_WIDTH  HRDATA to the master.
- s_hsel_i  in  SLV_NUMBER  per-slave HSEL from the decoder (address phase).
- s_hreadyout_i  in  SLV_NUMBER  per-slave HREADYOUT.
- s_hresp_i  in  SLV_NUMBER  per-slave HRESP.
- s_hrdata_i  in  SLV_NUMBER*DATA_WIDTH  slave i data in bits [i*DATA_WIDTH +: DATA_WIDTH].

## Operation
- Address-phase owner: the lowest index i with s_hsel_i[i]=1. If no bit is set, the owner is the default slave (DS).
- Data-phase registers: sel_q (index, $clog2(SLV_NUMBER) bits, minimum 1), slv_q (1 = real slave, 0 = DS), ds_err_q (DS transfer needs ERROR).
- Registers load only on clock edges where m_hready_o=1: slv_q <= |s_hsel_i; sel_q <= owner index; ds_err_q <= (~|s_hsel_i) & m_htrans_i[1].
- slv_q=1: m_hready_o=s_hreadyout_i[sel_q], m_hresp_o=s_hresp_i[sel_q], m_hrdata_o=slave sel_q data. All three outputs are combinational from the registers and slave inputs.
- slv_q=0: the outputs come from the DS FSM, and m_hrdata_o=0.
- DS FSM states:
  - DS_OKAY: hready=1, hresp=0.
  - DS_ERR1: hready=0, hresp=1.
  - DS_ERR2: hready=1, hresp=1.
- DS FSM transitions:
  - DS_OKAY -> DS_ERR1 when the address phase is accepted (m_hready_o=1), no HSEL is set, and HTRANS is NONSEQ or SEQ. Otherwise DS_OKAY is held.
  - DS_ERR1 -> DS_ERR2 unconditionally.
  - DS_ERR2 -> DS_ERR1 if the transfer accepted in this cycle is another unmapped NONSEQ/SEQ. Otherwise DS_ERR2 -> DS_OKAY.
- In DS_ERR1 the ERROR state is not taken if slv_q becomes 1. Address phases are never accepted in DS_ERR1, because m_hready_o=0 there.
- Unmapped IDLE or BUSY transfers get a zero-wait OKAY from DS.
- Several HSEL bits set at once (overlapping map): the lowest index wins, with no error.

## Timing
- Reset values (asynchronous assertion, released on clk_i): slv_q=0, sel_q=0, ds_err_q=0, FSM=DS_OKAY. With these values m_hready_o=1, m_hresp_o=0, m_hrdata_o=0.
- Mapped transfer: address accepted at edge n. From cycle n+1 the outputs track slave sel_q until that slave drives HREADYOUT=1. Latency added by this block is 0 cycles.
- Unmapped NONSEQ accepted at edge n:
  - cycle n+1: hready=0, hresp=1.
  - cycle n+2: hready=1, hresp=1. A pipelined next address phase is accepted here.
- Slave wait states hold m_hready_o=0, so sel_q is frozen and s_hsel_i changes during that time are ignored.
- Reset asserted mid-transfer (slave wait or DS_ERR1): outputs return to the reset values immediately, with no clock needed.

## Test plan
- Reset: assert rst_i while clk_i is stopped -> m_hready_o=1, m_hresp_o=0, m_hrdata_o=0.
- Mapped read: s_hsel_i=16'h0004, HTRANS=NONSEQ, s_hrdata_i slot 2=32'hDEAD_BEEF, slave 2 HREADYOUT 0,0,1 -> m_hready_o 0,0,1. m_hrdata_o=32'hDEAD_BEEF in the last cycle, m_hresp_o=0.
- Unmapped NONSEQ: s_hsel_i=0, HTRANS=2 -> next two cycles (hready,hresp)=(0,1),(1,1), then (1,0) after IDLE.
- Back-to-back unmapped SEQ after an unmapped NONSEQ -> (0,1),(1,1),(0,1),(1,1). Unmapped IDLE -> (1,0) with zero wait.
- Overlap: s_hsel_i=16'h0030 -> data phase is routed to slave 4, not slave 5. Change s_hsel_i during a slave-4 wait state -> routing stays on slave 4.
- Reset asserted in DS_ERR1 -> outputs are (1,0) within the same cycle, and the next unmapped NONSEQ after reset gives the full two-cycle ERROR again.
